// File: rtl/serial_link_fifo.sv
// serial_link_fifo: clocked serial TX, synchronised serial RX
// and a show-ahead RX FIFO with sticky error flags.
module serial_link_fifo #(
  parameter int WORD_W     = 32,
  parameter int DEPTH      = 4,
  parameter int CLK_DIV    = 8,
  parameter int RX_TIMEOUT = 1024
) (
  input  logic                     clock,
  input  logic                     reset_not,
  input  logic                     serial_data_in,
  input  logic                     serial_clock_in,
  output logic                     serial_data_out,
  output logic                     serial_clock_out,
  input  logic [WORD_W-1:0]        tx_word,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  output logic [WORD_W-1:0]        rx_word,
  output logic                     rx_valid,
  input  logic                     rx_pop,
  output logic [$clog2(DEPTH):0]   rx_count,
  output logic [2:0]               err_flags,
  input  logic                     err_clear
);

  localparam int FW = WORD_W + 2;
  localparam int TW = $clog2(2 * CLK_DIV);
  localparam int BW = $clog2(FW);
  localparam int RW = $clog2(WORD_W);
  localparam int OW = $clog2(RX_TIMEOUT + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [TW-1:0] T_HALF = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] T_GAP  = TW'(2 * CLK_DIV - 1);
  localparam logic [BW-1:0] B_LAST = BW'(FW - 1);
  localparam logic [RW-1:0] R_LAST = RW'(WORD_W - 1);
  localparam logic [OW-1:0] O_LAST = OW'(RX_TIMEOUT - 1);
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    GAP
  } tx_st_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_DATA,
    R_PARITY
  } rx_st_t;

  // ---------------- transmitter ----------------
  tx_st_t          tx_st_q, tx_st_d;
  logic [FW-1:0]   tx_sh_q, tx_sh_d;
  logic [BW-1:0]   tx_bit_q, tx_bit_d;
  logic [TW-1:0]   tx_tmr_q, tx_tmr_d;
  logic            sclk_q, sclk_d;
  logic            sdo_q, sdo_d;

  // TX sequencing; pin values are registered from the next state
  // so the serial clock and data pins are glitch-free.
  always_comb begin
    tx_st_d  = tx_st_q;
    tx_sh_d  = tx_sh_q;
    tx_bit_d = tx_bit_q;
    tx_tmr_d = tx_tmr_q;
    unique case (tx_st_q)
      IDLE: begin
        if (tx_valid) begin
          tx_sh_d  = {1'b1, tx_word, ^tx_word};
          tx_bit_d = '0;
          tx_tmr_d = T_HALF;
          tx_st_d  = LOW;
        end
      end
      LOW: begin
        if (tx_tmr_q == '0) begin
          tx_tmr_d = T_HALF;
          tx_st_d  = HIGH;
        end else begin
          tx_tmr_d = tx_tmr_q - TW'(1);
        end
      end
      HIGH: begin
        if (tx_tmr_q == '0) begin
          if (tx_bit_q == B_LAST) begin
            tx_tmr_d = T_GAP;
            tx_st_d  = GAP;
          end else begin
            tx_sh_d  = {tx_sh_q[FW-2:0], 1'b0};
            tx_bit_d = tx_bit_q + BW'(1);
            tx_tmr_d = T_HALF;
            tx_st_d  = LOW;
          end
        end else begin
          tx_tmr_d = tx_tmr_q - TW'(1);
        end
      end
      GAP: begin
        if (tx_tmr_q == '0) begin
          tx_st_d = IDLE;
        end else begin
          tx_tmr_d = tx_tmr_q - TW'(1);
        end
      end
      default: tx_st_d = IDLE;
    endcase
    sclk_d = (tx_st_d == HIGH);
    sdo_d  = ((tx_st_d == LOW) || (tx_st_d == HIGH))
           ? tx_sh_d[FW-1] : 1'b0;
  end

  // TX state registers
  always_ff @(posedge clock or negedge reset_not) begin
    if (!reset_not) begin
      tx_st_q  <= IDLE;
      tx_sh_q  <= '0;
      tx_bit_q <= '0;
      tx_tmr_q <= '0;
      sclk_q   <= 1'b0;
      sdo_q    <= 1'b0;
    end else begin
      tx_st_q  <= tx_st_d;
      tx_sh_q  <= tx_sh_d;
      tx_bit_q <= tx_bit_d;
      tx_tmr_q <= tx_tmr_d;
      sclk_q   <= sclk_d;
      sdo_q    <= sdo_d;
    end
  end

  assign tx_ready         = (tx_st_q == IDLE);
  assign serial_clock_out = sclk_q;
  assign serial_data_out  = sdo_q;

  // ---------------- receiver ----------------
  logic [1:0] sd_sync_q, sd_sync_d;
  logic [2:0] sc_sync_q, sc_sync_d;
  logic       rise;
  logic       samp;

  // two-flop synchronisers; third clock stage is the edge history
  always_comb begin
    sd_sync_d = {sd_sync_q[0], serial_data_in};
    sc_sync_d = {sc_sync_q[1:0], serial_clock_in};
  end

  // synchroniser registers
  always_ff @(posedge clock or negedge reset_not) begin
    if (!reset_not) begin
      sd_sync_q <= '0;
      sc_sync_q <= '0;
    end else begin
      sd_sync_q <= sd_sync_d;
      sc_sync_q <= sc_sync_d;
    end
  end

  assign rise = sc_sync_q[1] & ~sc_sync_q[2];
  assign samp = sd_sync_q[1];

  rx_st_t            rx_st_q, rx_st_d;
  logic [WORD_W-1:0] rx_sh_q, rx_sh_d;
  logic [RW-1:0]     rx_cnt_q, rx_cnt_d;
  logic [OW-1:0]     rx_tmo_q, rx_tmo_d;
  logic              push;
  logic              perr_set;
  logic              ferr_set;

  // RX frame decode with mid-frame idle timeout
  always_comb begin
    rx_st_d  = rx_st_q;
    rx_sh_d  = rx_sh_q;
    rx_cnt_d = rx_cnt_q;
    push     = 1'b0;
    perr_set = 1'b0;
    ferr_set = 1'b0;
    if (rise || (rx_st_q == R_IDLE)) begin
      rx_tmo_d = '0;
    end else begin
      rx_tmo_d = rx_tmo_q + OW'(1);
    end
    unique case (rx_st_q)
      R_IDLE: begin
        if (rise && samp) begin
          rx_cnt_d = '0;
          rx_st_d  = R_DATA;
        end
      end
      R_DATA: begin
        if (rise) begin
          rx_sh_d  = {rx_sh_q[WORD_W-2:0], samp};
          rx_cnt_d = rx_cnt_q + RW'(1);
          if (rx_cnt_q == R_LAST) begin
            rx_st_d = R_PARITY;
          end
        end else if (rx_tmo_q == O_LAST) begin
          ferr_set = 1'b1;
          rx_st_d  = R_IDLE;
        end
      end
      R_PARITY: begin
        if (rise) begin
          rx_st_d = R_IDLE;
          if ((^rx_sh_q) == samp) begin
            push = 1'b1;
          end else begin
            perr_set = 1'b1;
          end
        end else if (rx_tmo_q == O_LAST) begin
          ferr_set = 1'b1;
          rx_st_d  = R_IDLE;
        end
      end
      default: rx_st_d = R_IDLE;
    endcase
  end

  // RX state registers
  always_ff @(posedge clock or negedge reset_not) begin
    if (!reset_not) begin
      rx_st_q  <= R_IDLE;
      rx_sh_q  <= '0;
      rx_cnt_q <= '0;
      rx_tmo_q <= '0;
    end else begin
      rx_st_q  <= rx_st_d;
      rx_sh_q  <= rx_sh_d;
      rx_cnt_q <= rx_cnt_d;
      rx_tmo_q <= rx_tmo_d;
    end
  end

  // ---------------- RX FIFO ----------------
  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_q, wr_d;
  logic [AW-1:0]     rd_q, rd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              full;
  logic              pop;
  logic              wr_en;
  logic              ovf_set;

  // a pop frees the full slot in the same cycle, so push still lands
  always_comb begin
    full    = (cnt_q == C_FULL);
    pop     = rx_pop && (cnt_q != '0);
    wr_en   = push && (!full || pop);
    ovf_set = push && full && !pop;
    wr_d    = wr_en ? wr_q + AW'(1) : wr_q;
    rd_d    = pop ? rd_q + AW'(1) : rd_q;
    unique case ({wr_en, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO storage; contents are only visible while non-empty
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_q] <= rx_sh_q;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clock or negedge reset_not) begin
    if (!reset_not) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign rx_count = cnt_q;
  assign rx_valid = (cnt_q != '0);
  assign rx_word  = rx_valid ? mem_q[rd_q] : '0;

  // ---------------- sticky errors ----------------
  logic [2:0] err_q, err_d;

  // a set event in the clear cycle survives the clear
  always_comb begin
    err_d = (err_q & {3{~err_clear}})
          | {ferr_set, ovf_set, perr_set};
  end

  // error flag register
  always_ff @(posedge clock or negedge reset_not) begin
    if (!reset_not) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_flags = err_q;

endmodule

// File: doc/serial_link_fifo.md
SERIAL_LINK_FIFO -- requirements
Module: serial_link_fifo

Interface
REQ-001 Parameter WORD_W, 32: payload bits per frame, range 8..32.
REQ-002 Parameter DEPTH, 4: RX FIFO entries, power of two, range 2..16.
REQ-003 Parameter CLK_DIV, 8: system cycles per serial-clock half-period, range 2..255.
REQ-004 Parameter RX_TIMEOUT, 1024: idle system cycles mid-frame before abort.
REQ-005 clock  in  1  system clock; all state on rising edge.
REQ-006 reset_not  in  1  asynchronous active-low reset.
REQ-007 serial_data_in  in  1  RX data pin, asynchronous to clock.
REQ-008 serial_clock_in  in  1  RX bit clock pin, asynchronous to clock.
REQ-009 serial_data_out  out  1  TX data pin.
REQ-010 serial_clock_out  out  1  TX bit clock pin.
REQ-011 tx_word  in  WORD_W  word to send; sampled on accept.
REQ-012 tx_valid  in  1  request to send tx_word.
REQ-013 tx_ready  out  1  transmitter idle; accept when tx_valid&tx_ready.
REQ-014 rx_word  out  WORD_W  FIFO head (show-ahead).
REQ-015 rx_valid  out  1  FIFO non-empty.
REQ-016 rx_pop  in  1  discard head; ignored when rx_valid=0.
REQ-017 rx_count  out  clog2(DEPTH)+1  FIFO occupancy.
REQ-018 err_flags  out  3  sticky {frame_err, overflow, parity_err}.
REQ-019 err_clear  in  1  clears err_flags.

Function
REQ-020 Frame SHALL be: start bit 1, WORD_W data bits MSB first, even parity bit over data; data changes while clock low, valid on clock rising edge.
REQ-021 TX states SHALL be IDLE, LOW, HIGH, GAP.
REQ-022 IDLE: tx_ready=1, serial_clock_out=0, serial_data_out=0; on accept load shift register {1,tx_word,parity}, go LOW next cycle.
REQ-023 LOW: drive current bit, clock 0 for CLK_DIV cycles, then HIGH; HIGH: clock 1 for CLK_DIV cycles, then next bit's LOW, or GAP after the parity bit.
REQ-024 GAP: clock 0, data 0 for 2*CLK_DIV cycles, then IDLE; one frame spans (WORD_W+2)*2*CLK_DIV+2*CLK_DIV cycles after accept.
REQ-025 tx_ready SHALL be 0 in LOW, HIGH, GAP; tx_valid while not ready has no effect.
REQ-026 RX inputs SHALL pass a 2-flop synchroniser; bit sample = synchronised data on detected synchronised clock rising edge.
REQ-027 RX states SHALL be R_IDLE, R_DATA, R_PARITY; R_IDLE leaves only on a sampled 1 (start); sampled 0 in R_IDLE ignored.
REQ-028 R_DATA shifts WORD_W samples MSB first; R_PARITY checks even parity, returns to R_IDLE.
REQ-029 Good parity: push word at end of parity-detect cycle E; rx_valid/rx_count reflect it in E+1.
REQ-030 Bad parity: discard word, set parity_err.
REQ-031 No rising edge for RX_TIMEOUT cycles in R_DATA/R_PARITY: abort to R_IDLE, discard, set frame_err.
REQ-032 Push while full and no pop: discard incoming word, FIFO unchanged, set overflow.
REQ-033 Push and pop same cycle: both occur; rx_count unchanged, including when full; no overflow.
REQ-034 Pop when empty SHALL not change state; pointers wrap modulo DEPTH.
REQ-035 err_clear SHALL clear all flags; a set event in the same cycle wins.
REQ-036 TX and RX SHALL be fully independent; loopback pin-to-pin SHALL work.

Reset
REQ-037 reset_not=0 SHALL asynchronously force TX IDLE, RX R_IDLE, FIFO empty, rx_count=0, rx_valid=0, rx_word=0, err_flags=0, serial_clock_out=0, serial_data_out=0, tx_ready=1, synchronisers 0.
REQ-038 Reset mid-frame SHALL abort both directions with no partial word pushed; first accept allowed the cycle after release.

Verification
REQ-039 WORD_W=8, CLK_DIV=2, send 0xA5 -> serial_data_out 1,1,0,1,0,0,1,0,1,0 per bit; tx_ready low 44 cycles.
REQ-040 Loopback, send 0x12345678 -> rx_word=0x12345678, rx_valid=1, rx_count=1, err_flags=0.
REQ-041 DEPTH=4, five frames no pop -> rx_count=4, overflow=1, head is first word.
REQ-042 Full FIFO, pop in push cycle -> rx_count stays 4, overflow=0, new word at tail.
REQ-043 Inject odd-parity frame -> no push, parity_err=1; err_clear -> err_flags=0.
REQ-044 Stop serial_clock_in after 3 data bits -> frame_err=1 after RX_TIMEOUT cycles; next good frame received correctly.
